// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op and arbiter state types
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_ADD = 2'd1,
    ALU_XOR = 2'd2,
    ALU_SUB = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Searches last_i+1 .. wrap; the nearest valid requester after last_i wins.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest overwrites.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with registered issue and response
// ALU_ARB_LOCK_EN adds req_lock_i so the last-accepted requester can keep the ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [2*NUM_REQ-1:0] req_op_i,
  input  logic [W*NUM_REQ-1:0] req_a_i,
  input  logic [W*NUM_REQ-1:0] req_b_i,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock_i,
`endif
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [1:0]           alu_op_o,
  output logic [W-1:0]         alu_src_a_o,
  output logic [W-1:0]         alu_src_b_o,
  input  logic [W-1:0]         alu_result_i,
  output logic [NUM_REQ-1:0]   resp_valid_o,
  output logic [W-1:0]         resp_data_o,
  output logic                 resp_zero_o,
  input  logic [NUM_REQ-1:0]   resp_ready_i
);

  localparam int IW = idx_width(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  alu_op_t       op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  data_q, data_d;
  logic          zero_q, zero_d;

  logic [NUM_REQ-1:0] rr_gnt, win_oh, last_oh;
  logic [IW-1:0]      rr_idx, win_idx;
  logic               grant_pt, accept;

  logic [1:0]   op_arr [NUM_REQ];
  logic [W-1:0] a_arr  [NUM_REQ];
  logic [W-1:0] b_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op_i[2*g +: 2];
    assign a_arr[g]  = req_a_i[W*g +: W];
    assign b_arr[g]  = req_b_i[W*g +: W];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i     (req_valid_i),
    .last_i    (last_q),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx)
  );

  always_comb begin
    last_oh         = '0;
    last_oh[last_q] = 1'b1;
  end

`ifdef ALU_ARB_LOCK_EN
  logic grant_vld_q;
  logic lock_hit;

  // Only a requester that actually won since reset may hold the lock.
  assign lock_hit = grant_vld_q & req_valid_i[last_q] & req_lock_i[last_q];
  assign win_oh   = lock_hit ? last_oh : rr_gnt;
  assign win_idx  = lock_hit ? last_q : rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld_q <= 1'b0;
    end else if (accept) begin
      grant_vld_q <= 1'b1;
    end
  end
`else
  assign win_oh  = rr_gnt;
  assign win_idx = rr_idx;
`endif

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    zero_d       = zero_q;
    grant_pt     = 1'b0;
    accept       = 1'b0;
    req_ready_o  = '0;
    resp_valid_o = '0;

    case (state_q)
      ARB_IDLE: begin
        grant_pt = 1'b1;
      end
      ARB_ISSUE: begin
        data_d  = alu_result_i;
        zero_d  = (alu_result_i == '0);
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        resp_valid_o = last_oh;
        if (resp_ready_i[last_q]) begin
          grant_pt = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // The reset term keeps ready low while reset is held, so no request is accepted during reset.
    if (grant_pt && rst_n) begin
      req_ready_o = win_oh;
      if (|req_valid_i) begin
        accept  = 1'b1;
        state_d = ARB_ISSUE;
        last_d  = win_idx;
        op_d    = alu_op_t'(op_arr[win_idx]);
        a_d     = a_arr[win_idx];
        b_d     = b_arr[win_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= LAST_RST;
      op_q    <= ALU_AND;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_op_o    = op_q;
  assign alu_src_a_o = a_q;
  assign alu_src_b_o = b_q;
  assign resp_data_o = data_q;
  assign resp_zero_o = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an external ALU model
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_result, resp_data;
  logic           resp_zero;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  always #5 clk = ~clk;

  // The shared ALU the arbiter drives.
  always_comb begin
    case (alu_op)
      2'd0:    alu_result = alu_a & alu_b;
      2'd1:    alu_result = alu_a + alu_b;
      2'd2:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a - alu_b;
    endcase
  end

  alu_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
`ifdef ALU_ARB_LOCK_EN
    .req_lock_i   (req_lock),
`endif
    .req_ready_o  (req_ready),
    .alu_op_o     (alu_op),
    .alu_src_a_o  (alu_a),
    .alu_src_b_o  (alu_b),
    .alu_result_i (alu_result),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_zero_o  (resp_zero),
    .resp_ready_i (resp_ready)
  );

  function automatic logic [W-1:0] ref_result(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int ia, ib, r, m;
    ia = int'(a);
    ib = int'(b);
    m  = 1 << W;
    case (op)
      2'd0:    r = ia & ib;
      2'd1:    r = (ia + ib) % m;
      2'd2:    r = ia ^ ib;
      default: r = (ia - ib + m) % m;
    endcase
    return W'(r);
  endfunction

  function automatic int rr_model(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic idle_inputs();
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock   = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = 1'b1;
    req_op[2*i +: 2]  = op;
    req_a[W*i +: W]   = a;
    req_b[W*i +: W]   = b;
  endtask

  task automatic reroll(input int i);
    set_req(i, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
  endtask

  function automatic logic [W-1:0] exp_of(int i);
    return ref_result(req_op[2*i +: 2], req_a[W*i +: W], req_b[W*i +: W]);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok, seen;
    rst_n = 1'b0;
    idle_inputs();
    req_valid = 2'b11;
    req_a     = 16'hA5C3;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    n_checks++;
    if (resp_valid !== 2'b00 || resp_data !== 8'h00 || resp_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got valid=%b data=%h zero=%b expected 00/00/0", resp_valid, resp_data, resp_zero);
    end
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== 18'h0) begin
      n_fail++; $display("FAIL reset_alu: got op=%0d a=%h b=%h expected 0/00/00", alu_op, alu_a, alu_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    set_req(0, ALU_ADD, 8'h12, 8'h34);
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_first_accept: got no ready expected ready[0]"); end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (alu_a !== 8'h12 || alu_b !== 8'h34) begin
      n_fail++; $display("FAIL reset_issue_regs: got a=%h b=%h expected 12/34", alu_a, alu_b);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_op, alu_a, alu_b, resp_valid, resp_data, resp_zero} !== 29'h0) begin
      n_fail++; $display("FAIL reset_mid_issue: got op=%0d a=%h b=%h rv=%b expected all 0", alu_op, alu_a, alu_b, resp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      #1;
      if (resp_valid !== 2'b00) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_no_resp: got response after reset expected none"); end
  endtask

  task automatic test_single_op();
    bit ok;
    apply_reset();
    set_req(0, ALU_ADD, 8'h7F, 8'h01);
    wait_ready(0, ok);
    n_checks++;
    if (!ok || req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00 || alu_op !== 2'd1 || alu_a !== 8'h7F || alu_b !== 8'h01) begin
      n_fail++; $display("FAIL single_issue: got rv=%b op=%0d a=%h b=%h expected 00/1/7f/01", resp_valid, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== 8'h80 || resp_zero !== 1'b0) begin
      n_fail++; $display("FAIL single_resp: got rv=%b data=%h zero=%b expected 01/80/0", resp_valid, resp_data, resp_zero);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_consumed: got rv=%b expected 00", resp_valid); end
  endtask

  task automatic test_wrap_zero();
    logic [1:0]   ops  [4] = '{2'd3, 2'd3, 2'd0, 2'd1};
    logic [W-1:0] as   [4] = '{8'h05, 8'h00, 8'hF0, 8'hFF};
    logic [W-1:0] bs   [4] = '{8'h05, 8'h01, 8'h0F, 8'h01};
    logic [W-1:0] exps [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    bit ok;
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      set_req(1, ops[t], as[t], bs[t]);
      wait_ready(1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wrap_ready[%0d]: got no ready expected ready[1]", t); end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      n_checks++;
      if (resp_valid !== 2'b10 || resp_data !== exps[t] || resp_zero !== (exps[t] == 8'h00)) begin
        n_fail++; $display("FAIL wrap_resp[%0d]: got rv=%b data=%h zero=%b expected 10/%h/%b",
                           t, resp_valid, resp_data, resp_zero, exps[t], exps[t] == 8'h00);
      end
      resp_ready = 2'b10;
      @(negedge clk);
      resp_ready = 2'b00;
    end
  endtask

  task automatic test_contention();
    int   grants[$];
    exp_t q[$];
    exp_t e;
    int   g, ri;
    apply_reset();
    reroll(0);
    reroll(1);
    resp_ready = 2'b11;
    for (int c = 0; c < 40 && grants.size() < 8; c++) begin
      #1;
      if ((resp_valid & resp_ready) != 0) begin
        ri = resp_valid[1] ? 1 : 0;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL contention_spurious: got response for req%0d expected none", ri);
        end else begin
          e = q.pop_front();
          if (ri != e.idx || resp_valid !== onehot(e.idx) || resp_data !== e.data) begin
            n_fail++; $display("FAIL contention_resp: got rv=%b data=%h expected req%0d data=%h", resp_valid, resp_data, e.idx, e.data);
          end
        end
      end
      g = req_ready[0] ? 0 : (req_ready[1] ? 1 : -1);
      if (g >= 0) begin
        e.idx  = g;
        e.data = exp_of(g);
        q.push_back(e);
        grants.push_back(g);
      end
      @(negedge clk);
      if (g >= 0) reroll(g);
    end
    req_valid = '0;
    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      #1;
      if ((resp_valid & resp_ready) != 0) begin
        e = q.pop_front();
        n_checks++;
        if (resp_valid !== onehot(e.idx) || resp_data !== e.data) begin
          n_fail++; $display("FAIL contention_drain: got rv=%b data=%h expected req%0d data=%h", resp_valid, resp_data, e.idx, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (grants.size() != 8 || q.size() != 0) begin
      n_fail++; $display("FAIL contention_count: got %0d grants %0d pending expected 8/0", grants.size(), q.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++;
      if (grants[k] != k % 2) begin n_fail++; $display("FAIL contention_order[%0d]: got req%0d expected req%0d", k, grants[k], k % 2); end
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_back_pressure();
    bit           ok;
    logic [W-1:0] e0, e1;
    apply_reset();
    set_req(0, ALU_XOR, W'($urandom), W'($urandom));
    e0 = exp_of(0);
    wait_ready(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_first_accept: got no ready expected ready[0]"); end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, ALU_SUB, W'($urandom), W'($urandom));
    e1 = exp_of(1);
    @(negedge clk);
    resp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (resp_valid !== 2'b01 || resp_data !== e0 || req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got rv=%b data=%h rdy=%b expected 01/%h/00", c, resp_valid, resp_data, req_ready, e0);
      end
      @(negedge clk);
    end
    resp_ready = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_same_cycle_accept: got rdy=%b expected 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 2'b00;
    req_valid  = '0;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_issue_gap: got rv=%b expected 00", resp_valid); end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 2'b10 || resp_data !== e1) begin
      n_fail++; $display("FAIL bp_second_resp: got rv=%b data=%h expected 10/%h", resp_valid, resp_data, e1);
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_random();
    int           last, idx, w, age;
    bit           busy;
    logic [W-1:0] exp_d;
    logic [N-1:0] exp_rv, exp_rdy;
    apply_reset();
    last  = N - 1;
    busy  = 1'b0;
    age   = 0;
    idx   = 0;
    exp_d = '0;
    for (int c = 0; c < 300; c++) begin
      req_valid  = N'($urandom);
      req_op     = (2*N)'($urandom);
      req_a      = (W*N)'($urandom);
      req_b      = (W*N)'($urandom);
      resp_ready = N'($urandom);
      #1;
      exp_rv = (busy && age >= 2) ? onehot(idx) : '0;
      n_checks++;
      if (resp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_resp_valid[%0d]: got %b expected %b", c, resp_valid, exp_rv); end
      if (exp_rv != 0) begin
        n_checks++;
        if (resp_data !== exp_d || resp_zero !== (exp_d == '0)) begin
          n_fail++; $display("FAIL rand_resp_data[%0d]: got %h/%b expected %h/%b", c, resp_data, resp_zero, exp_d, exp_d == '0);
        end
        if (resp_ready[idx]) busy = 1'b0;
      end
      exp_rdy = '0;
      w       = -1;
      if (!busy) begin
        w = rr_model(req_valid, last);
        if (w >= 0) exp_rdy = onehot(w);
      end
      n_checks++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
      if (w >= 0) begin
        busy  = 1'b1;
        age   = 0;
        idx   = w;
        last  = w;
        exp_d = exp_of(w);
      end
      @(negedge clk);
      age++;
    end
    req_valid  = '0;
    resp_ready = '1;
    repeat (3) @(negedge clk);
    resp_ready = '0;
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    int grants[$];
    int g, n0;
    apply_reset();
    reroll(0);
    reroll(1);
    req_lock   = 2'b01;
    resp_ready = 2'b11;
    n0         = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #1;
      g = req_ready[0] ? 0 : (req_ready[1] ? 1 : -1);
      if (g >= 0) grants.push_back(g);
      if (g == 0) n0++;
      @(negedge clk);
      if (g >= 0) reroll(g);
      if (n0 == 3) req_lock = 2'b00;
    end
    n_checks++;
    if (grants.size() != 4) begin n_fail++; $display("FAIL lock_count: got %0d grants expected 4", grants.size()); end
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++;
      if (grants[k] != ((k < 3) ? 0 : 1)) begin
        n_fail++; $display("FAIL lock_order[%0d]: got req%0d expected req%0d", k, grants[k], (k < 3) ? 0 : 1);
      end
    end
    req_valid  = '0;
    repeat (4) @(negedge clk);
    resp_ready = '0;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_op();
    test_wrap_zero();
    test_contention();
    test_back_pressure();
    test_random();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
